// File: rtl/pe_skew_feeder_if.sv
// Handshake and data bundle between the vector source and the skew feeder.
// master = source/bench side, slave = feeder side.
interface pe_skew_feeder_if #(
   parameter int D_W = 16,
   parameter int N   = 4,
   parameter int K_W = 8
);
   logic               I_START;
   logic [K_W-1:0]     I_LEN;
   logic               I_VLD;
   logic               O_RDY;
   logic [N*D_W-1:0]   I_DATA;
   logic [N-1:0]       O_VLD;
   logic [N*D_W-1:0]   O_X;
   logic               O_BUSY;
   logic               O_DONE;

   modport master (
      output I_START, I_LEN, I_VLD, I_DATA,
      input  O_RDY, O_VLD, O_X, O_BUSY, O_DONE
   );

   modport slave (
      input  I_START, I_LEN, I_VLD, I_DATA,
      output O_RDY, O_VLD, O_X, O_BUSY, O_DONE
   );
endinterface

// File: rtl/pe_skew_feeder.sv
// Left-edge feeder of the PE array: accepts I_LEN column vectors per tile and
// skews them so lane i lags by i cycles, then drains and pulses O_DONE.
module pe_skew_feeder #(
   parameter int D_W = 16,
   parameter int N   = 4,
   parameter int K_W = 8
) (
   input  logic               I_CLK,
   input  logic               I_ASYN_RSTN,
   pe_skew_feeder_if.slave    bus
);
   localparam int              DC_W       = (N > 1) ? $clog2(N) : 1;
   localparam logic [DC_W-1:0] DRAIN_INIT = DC_W'(N - 1);
   localparam logic [DC_W-1:0] DRAIN_ONE  = DC_W'(1);
   localparam logic [K_W-1:0]  CNT_ONE    = K_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nxt_state;
   logic [K_W-1:0]    r_cnt;
   logic [K_W-1:0]    w_nxt_cnt;
   logic [K_W-1:0]    r_len;
   logic [K_W-1:0]    w_nxt_len;
   logic [DC_W-1:0]   r_drain;
   logic [DC_W-1:0]   w_nxt_drain;
   logic              r_rdy;
   logic              r_busy;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_acc;
   logic [N-1:0]      w_vld;
   logic [N*D_W-1:0]  w_x;

   assign w_acc = bus.I_VLD & r_rdy;

   // Control state, counters and registered handshake/status outputs.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_drain <= '0;
         r_rdy   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_len   <= w_nxt_len;
         r_drain <= w_nxt_drain;
         r_rdy   <= (w_nxt_state == ST_LOAD);
         r_busy  <= (w_nxt_state != ST_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   // Next-state: the last beat is detected as count+1 == length, so a
   // full-scale length never needs the counter to reach 2^K_W.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_len   = r_len;
      w_nxt_drain = r_drain;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.I_START) begin
               if (bus.I_LEN != '0) begin
                  w_nxt_state = ST_LOAD;
                  w_nxt_cnt   = '0;
                  w_nxt_len   = bus.I_LEN;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (w_acc) begin
               if ((r_cnt + CNT_ONE) == r_len) begin
                  w_nxt_state = ST_FLUSH;
                  w_nxt_drain = DRAIN_INIT;
               end else begin
                  w_nxt_cnt   = r_cnt + CNT_ONE;
               end
            end else begin
               w_nxt_state = ST_LOAD;
            end
         end
         ST_FLUSH: begin
            if (r_drain == '0) begin
               w_nxt_state = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_nxt_drain = r_drain - DRAIN_ONE;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [D_W-1:0] r_d [0:gi];
      logic           r_v [0:gi];

      // Lane gi delay line of gi+1 stages; free-running, zero data when idle.
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
         if (!I_ASYN_RSTN) begin
            for (int s = 0; s <= gi; s++) begin
               r_d[s] <= '0;
               r_v[s] <= 1'b0;
            end
         end else begin
            r_v[0] <= w_acc;
            r_d[0] <= w_acc ? bus.I_DATA[gi*D_W +: D_W] : '0;
            for (int s = 1; s <= gi; s++) begin
               r_d[s] <= r_d[s-1];
               r_v[s] <= r_v[s-1];
            end
         end
      end

      assign w_vld[gi]             = r_v[gi];
      assign w_x[gi*D_W +: D_W]    = r_d[gi];
   end

   assign bus.O_RDY  = r_rdy;
   assign bus.O_BUSY = r_busy;
   assign bus.O_DONE = r_done;
   assign bus.O_VLD  = w_vld;
   assign bus.O_X    = w_x;
endmodule
